// File: rtl/flop_bank_arbiter.sv
// flop_bank_arbiter: round-robin write arbiter with locked bursts over a DEPTH x N flop bank, one registered read port
module flop_bank_arbiter #(
  parameter int N = 4,
  parameter int NREQ = 4,
  parameter int DEPTH = 8,
  parameter int AW = 3,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   lock,
  input  logic [NREQ*AW-1:0] wr_addr,
  input  logic [NREQ*N-1:0] wr_data,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  input  logic [AW-1:0]     rd_addr,
  output logic [N-1:0]      rd_data
);
  localparam int OW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic {IDLE, OWNED} state_t;
  state_t state, state_n;
  logic [OW-1:0] ptr, ptr_n, owner, owner_n, win, base;
  logic [CW-1:0] cnt, cnt_n;
  logic [N-1:0] bank [DEPTH];
  logic hold, we;
  logic [AW-1:0] waddr;
  logic [N-1:0] wdata;
  always_comb begin
    hold = state == OWNED && req[owner] && lock[owner] && 32'(cnt) < MAX_BURST;
    base = state == OWNED ? OW'((int'(owner) + 1) % NREQ) : ptr;
    win = base;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[(int'(base) + i) % NREQ]) win = OW'((int'(base) + i) % NREQ);
    state_n = hold || |req ? OWNED : IDLE;
    owner_n = hold ? owner : |req ? win : owner;
    cnt_n = hold ? cnt + 1'b1 : |req ? CW'(1) : '0;
    ptr_n = state == OWNED && !hold ? base : ptr;
    waddr = wr_addr[int'(owner)*AW +: AW];
    wdata = wr_data[int'(owner)*N +: N];
    we = state == OWNED && req[owner] && 32'(waddr) < DEPTH;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      owner <= '0;
      cnt <= '0;
      rd_data <= '0;
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      owner <= owner_n;
      cnt <= cnt_n;
      if (we) bank[waddr] <= wdata;
      rd_data <= 32'(rd_addr) < DEPTH ? bank[rd_addr] : '0;
    end
  assign grant = state == OWNED ? NREQ'(1) << owner : '0;
  assign busy = state == OWNED;
endmodule

// File: tb/tb_flop_bank_arbiter.sv
// tb_flop_bank_arbiter: directed vector table plus hand-written burst/handoff/reset sequences
module tb_flop_bank_arbiter;
  logic clk = 0, reset = 0, busy;
  logic [3:0] req = 0, lock = 0, grant, rd_data;
  logic [11:0] wr_addr = 0;
  logic [15:0] wr_data = 0;
  logic [2:0] rd_addr = 0;
  int checks = 0, errors = 0;
  typedef struct {
    logic rs;
    logic [3:0] rq, lk;
    logic [11:0] wa;
    logic [15:0] wd;
    logic [2:0] ra;
    logic [3:0] eg, er;
  } vec_t;
  vec_t tbl[8];
  flop_bank_arbiter dut (.clk(clk), .reset(reset), .req(req), .lock(lock), .wr_addr(wr_addr),
    .wr_data(wr_data), .grant(grant), .busy(busy), .rd_addr(rd_addr), .rd_data(rd_data));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic do_reset;
    reset = 1;
    req = 0;
    lock = 0;
    #2;
    chk("reset grant", grant, 0);
    chk("reset busy", busy, 0);
    chk("reset rd_data", rd_data, 0);
    tick();
    reset = 0;
  endtask
  initial begin
    tbl[0] = '{1'b1, 4'h1, 4'h0, 12'h002, 16'h000A, 3'd2, 4'h1, 4'h0};
    tbl[1] = '{1'b0, 4'h1, 4'h0, 12'h002, 16'h000A, 3'd2, 4'h1, 4'h0};
    tbl[2] = '{1'b0, 4'h0, 4'h0, 12'h002, 16'h000A, 3'd2, 4'h0, 4'hA};
    tbl[3] = '{1'b1, 4'hF, 4'h0, 12'h000, 16'h4321, 3'd0, 4'h1, 4'h0};
    tbl[4] = '{1'b0, 4'hF, 4'h0, 12'h000, 16'h4321, 3'd0, 4'h2, 4'h0};
    tbl[5] = '{1'b0, 4'hF, 4'h0, 12'h000, 16'h4321, 3'd0, 4'h4, 4'h1};
    tbl[6] = '{1'b0, 4'hF, 4'h0, 12'h000, 16'h4321, 3'd0, 4'h8, 4'h2};
    tbl[7] = '{1'b0, 4'hF, 4'h0, 12'h000, 16'h4321, 3'd0, 4'h1, 4'h3};
    for (int v = 0; v < 8; v++) begin
      if (tbl[v].rs) do_reset();
      req = tbl[v].rq;
      lock = tbl[v].lk;
      wr_addr = tbl[v].wa;
      wr_data = tbl[v].wd;
      rd_addr = tbl[v].ra;
      tick();
      chk($sformatf("vec%0d grant", v), grant, tbl[v].eg);
      chk($sformatf("vec%0d busy", v), busy, |tbl[v].eg);
      chk($sformatf("vec%0d rd_data", v), rd_data, tbl[v].er);
    end
    do_reset();
    req = 4'b0011;
    lock = 4'b0001;
    wr_addr = {3'd0, 3'd0, 3'd4, 3'd1};
    rd_addr = 1;
    for (int k = 1; k <= 5; k++) begin
      wr_data = {12'h000, 4'(k)};
      tick();
      chk($sformatf("burst edge%0d grant", k), grant, k < 5 ? 4'b0001 : 4'b0010);
      if (k >= 3) chk($sformatf("burst edge%0d rd", k), rd_data, 4'(k - 1));
    end
    req = 0;
    tick();
    chk("burst final rd", rd_data, 5);
    chk("burst idle grant", grant, 0);
    do_reset();
    req = 4'b0100;
    lock = 4'b0100;
    wr_addr = {3'd7, 3'd6, 3'd0, 3'd0};
    wr_data = 16'h0900;
    rd_addr = 6;
    tick();
    chk("drop own2 grant", grant, 4'b0100);
    req = 4'b1100;
    tick();
    chk("drop hold grant", grant, 4'b0100);
    req = 4'b1000;
    wr_data = 16'h0F00;
    tick();
    chk("drop handoff grant", grant, 4'b1000);
    req = 0;
    tick();
    chk("drop no-write rd", rd_data, 9);
    do_reset();
    req = 4'b0001;
    wr_addr = 12'h005;
    wr_data = 16'h0007;
    rd_addr = 5;
    tick();
    tick();
    chk("raw old value", rd_data, 0);
    req = 0;
    tick();
    chk("raw new value", rd_data, 7);
    rd_addr = 7;
    wr_addr = 12'h007;
    req = 4'b0001;
    tick();
    tick();
    req = 0;
    tick();
    tick();
    chk("addr7 write", rd_data, 7);
    do_reset();
    req = 4'b0001;
    lock = 4'b0001;
    wr_addr = 12'h003;
    wr_data = 16'h000B;
    rd_addr = 3;
    tick();
    tick();
    tick();
    chk("pre-reset rd", rd_data, 4'hB);
    chk("pre-reset grant", grant, 4'b0001);
    #2;
    reset = 1;
    #1;
    chk("async grant", grant, 0);
    chk("async busy", busy, 0);
    chk("async rd_data", rd_data, 0);
    tick();
    reset = 0;
    req = 4'b1000;
    lock = 0;
    wr_addr = 12'h000;
    wr_data = 16'h0000;
    tick();
    chk("post-reset grant", grant, 4'b1000);
    req = 0;
    for (int a = 0; a < 8; a++) begin
      rd_addr = 3'(a);
      tick();
      chk($sformatf("cleared bank%0d", a), rd_data, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
